// File: rtl/rx_frame_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// rx_frame_ctrl_pkg
// Shared definitions for the receive frame controller: FSM state encoding,
// default parameter values and a small width helper.
// -----------------------------------------------------------------------------
package rx_frame_ctrl_pkg;

   localparam int DIV_DEF   = 50;
   localparam int TO_DEF    = 40;
   localparam int DEPTH_DEF = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RECV = 2'd1,
      ST_GAP  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   // Address width that stays at least one bit wide for a single-entry store.
   function automatic int addr_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO without fall-through: a pushed word is visible on dout
// from the cycle after the push. dout reads as zero while empty.
//
// Ports
//   clk    in   clock, rising edge
//   reset  in   synchronous, active-low; empties the FIFO
//   push   in   write din (ignored when full unless a pop happens too)
//   din    in   write data
//   pop    in   remove head word (ignored when empty)
//   dout   out  head word, zero when empty
//   empty  out  no words stored
//   full   out  DEPTH words stored
// -----------------------------------------------------------------------------
module sync_fifo
   import rx_frame_ctrl_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int DEPTH = DEPTH_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             empty,
   output logic             full
);

   localparam int AW = addr_w(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic             w_wr_ok;
   logic             w_rd_ok;

   assign empty   = (r_count == '0);
   assign full    = (r_count == CW'(DEPTH));
   assign w_rd_ok = pop && !empty;
   // A full FIFO still accepts a write when the head leaves in the same cycle.
   assign w_wr_ok = push && (!full || w_rd_ok);
   assign dout    = empty ? '0 : r_mem[r_rd_ptr];

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_wr_ok) begin
            r_wr_ptr <= (r_wr_ptr == AW'(DEPTH - 1)) ? '0 : r_wr_ptr + AW'(1);
         end
         if (w_rd_ok) begin
            r_rd_ptr <= (r_rd_ptr == AW'(DEPTH - 1)) ? '0 : r_rd_ptr + AW'(1);
         end
         case ({w_wr_ok, w_rd_ok})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Storage carries no reset; validity is tracked by the pointers and count.
   always_ff @(posedge clk) begin
      if (w_wr_ok) begin
         r_mem[r_wr_ptr] <= din;
      end
   end

endmodule

// File: rtl/rx_frame_ctrl.sv
// -----------------------------------------------------------------------------
// rx_frame_ctrl
// Frame controller for a serial word receiver. Generates the bit strobe,
// enables the receiver for a requested number of words, buffers received
// words in an output FIFO and reports frame end, overflow and timeout.
//
// Ports
//   clk        in   clock, rising edge
//   reset      in   synchronous, active-low
//   start      in   pulse; request a frame of num_words words (IDLE only)
//   abort      in   pulse; end the current frame
//   num_words  in   words per frame, sampled when start is accepted
//   bit_tick   out  one-clk strobe every DIV clks
//   rx_en      out  receiver enable, high only while waiting for a word
//   rx_word    in   word from the receiver
//   rx_rdy     in   receiver word-ready level; a rising edge is a new word
//   out_data   out  FIFO head word
//   out_valid  out  FIFO non-empty
//   out_ready  in   consumer takes out_data when out_valid is high
//   busy       out  frame in progress (not IDLE)
//   done       out  one-clk pulse at frame end
//   overflow   out  sticky; a word was dropped on a full FIFO
//   timeout    out  sticky; the frame ended waiting too long for a word
// -----------------------------------------------------------------------------
module rx_frame_ctrl
   import rx_frame_ctrl_pkg::*;
#(
   parameter int DIV      = DIV_DEF,
   parameter int TO_TICKS = TO_DEF,
   parameter int DEPTH    = DEPTH_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        abort,
   input  logic [3:0]  num_words,
   output logic        bit_tick,
   output logic        rx_en,
   input  logic [31:0] rx_word,
   input  logic        rx_rdy,
   output logic [31:0] out_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        busy,
   output logic        done,
   output logic        overflow,
   output logic        timeout
);

   localparam int TW = $clog2(TO_TICKS + 1);

   state_t        r_state;
   state_t        w_next;
   logic [7:0]    r_tick_cnt;
   logic [3:0]    r_remaining;
   logic [TW-1:0] r_to_cnt;
   logic          r_rdy_q;
   logic          r_overflow;
   logic          r_timeout;

   logic          w_tick;
   logic          w_start_ok;
   logic          w_word_ev;
   logic          w_push;
   logic          w_pop;
   logic          w_to_hit;
   logic          w_fifo_empty;
   logic          w_fifo_full;

   assign w_tick     = (r_tick_cnt == 8'(DIV - 1));
   assign w_start_ok = (r_state == ST_IDLE) && start;
   assign w_word_ev  = (r_state == ST_RECV) && rx_rdy && !r_rdy_q;
   // Abort beats a simultaneous word: the word is neither stored nor counted.
   assign w_push     = w_word_ev && !abort;
   assign w_pop      = !w_fifo_empty && out_ready;
   // Final permitted tick in RECV with no word arriving in the same cycle.
   assign w_to_hit   = (r_state == ST_RECV) && w_tick && !w_word_ev &&
                       (r_to_cnt == TW'(TO_TICKS - 1));

   assign bit_tick  = w_tick;
   assign out_valid = !w_fifo_empty;
   assign overflow  = r_overflow;
   assign timeout   = r_timeout;

   // State register
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state logic
   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_next = (num_words == 4'd0) ? ST_DONE : ST_RECV;
            end
         end
         ST_RECV: begin
            if (abort || w_to_hit) begin
               w_next = ST_DONE;
            end else if (w_word_ev) begin
               w_next = ST_GAP;
            end
         end
         ST_GAP: begin
            if (abort) begin
               w_next = ST_DONE;
            end else if (w_tick) begin
               w_next = (r_remaining != 4'd0) ? ST_RECV : ST_DONE;
            end
         end
         ST_DONE: w_next = ST_IDLE;
         default: w_next = ST_IDLE;
      endcase
   end

   // Output decode
   always_comb begin
      rx_en = 1'b0;
      busy  = 1'b1;
      done  = 1'b0;
      case (r_state)
         ST_IDLE: busy  = 1'b0;
         ST_RECV: rx_en = 1'b1;
         ST_DONE: done  = 1'b1;
         default: ;
      endcase
   end

   // Bit strobe, word accounting, timeout and status flags
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_tick_cnt  <= '0;
         r_remaining <= '0;
         r_to_cnt    <= '0;
         r_rdy_q     <= 1'b0;
         r_overflow  <= 1'b0;
         r_timeout   <= 1'b0;
      end else begin
         r_rdy_q    <= rx_rdy;
         r_tick_cnt <= w_tick ? '0 : r_tick_cnt + 8'd1;
         if (w_start_ok) begin
            r_remaining <= num_words;
            r_to_cnt    <= '0;
            r_overflow  <= 1'b0;
            r_timeout   <= 1'b0;
         end else begin
            if (w_push) begin
               r_remaining <= r_remaining - 4'd1;
               r_to_cnt    <= '0;
            end else if ((r_state == ST_RECV) && w_tick) begin
               r_to_cnt <= r_to_cnt + TW'(1);
            end
            // A dropped word still counts toward the frame length.
            if (w_push && w_fifo_full && !w_pop) begin
               r_overflow <= 1'b1;
            end
            if (w_to_hit && !abort) begin
               r_timeout <= 1'b1;
            end
         end
      end
   end

   sync_fifo #(
      .WIDTH (32),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (w_push),
      .din   (rx_word),
      .pop   (w_pop),
      .dout  (out_data),
      .empty (w_fifo_empty),
      .full  (w_fifo_full)
   );

endmodule

// File: tb/tb_rx_frame_ctrl.sv
// -----------------------------------------------------------------------------
// tb_rx_frame_ctrl
// Self-checking bench for rx_frame_ctrl with a behavioural receiver and a
// queue-based scoreboard of words sent versus words delivered.
// -----------------------------------------------------------------------------
module tb_rx_frame_ctrl;

   localparam int DIV      = 50;
   localparam int TO_TICKS = 40;
   localparam int DEPTH    = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic [3:0]  num_words = 4'd0;
   logic        bit_tick;
   logic        rx_en;
   logic [31:0] rx_word = 32'd0;
   logic        rx_rdy = 1'b0;
   logic [31:0] out_data;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic        busy;
   logic        done;
   logic        overflow;
   logic        timeout;

   int total = 0;
   int bad   = 0;

   logic [31:0] sent_q[$];
   logic [31:0] got_q[$];
   logic [31:0] fixed_q[$];
   logic        rcv_on = 1'b0;
   int          rcv_wait = 3;
   int          done_cnt = 0;
   int          rxen_cnt = 0;

   always #5 clk = ~clk;

   rx_frame_ctrl #(
      .DIV      (DIV),
      .TO_TICKS (TO_TICKS),
      .DEPTH    (DEPTH)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .abort     (abort),
      .num_words (num_words),
      .bit_tick  (bit_tick),
      .rx_en     (rx_en),
      .rx_word   (rx_word),
      .rx_rdy    (rx_rdy),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .busy      (busy),
      .done      (done),
      .overflow  (overflow),
      .timeout   (timeout)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Consumer / event monitor, sampled mid-cycle.
   initial forever begin
      @(negedge clk);
      if (out_valid && out_ready) got_q.push_back(out_data);
      if (done) done_cnt++;
      if (rx_en) rxen_cnt++;
   end

   // Receiver model: while enabled, wait a random time then raise rx_rdy for
   // one cycle with a new word; the word is recorded as sent.
   initial forever begin
      @(posedge clk);
      #1;
      if (rx_rdy) begin
         rx_rdy = 1'b0;
      end else if (rcv_on && rx_en) begin
         if (rcv_wait > 0) begin
            rcv_wait--;
         end else begin
            if (fixed_q.size() > 0) rx_word = fixed_q.pop_front();
            else rx_word = $urandom;
            rx_rdy = 1'b1;
            sent_q.push_back(rx_word);
            rcv_wait = $urandom_range(0, 30);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got=running expected=finished");
      $fatal(1, "watchdog");
   end

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic start_frame(input logic [3:0] n);
      cyc(1);
      start     = 1'b1;
      num_words = n;
      cyc(1);
      start     = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int limit, output int cycles);
      cycles = 0;
      while (!done && cycles < limit) begin
         cyc(1);
         cycles++;
      end
      chk({tag, "_done_seen"}, done, 1'b1);
   endtask

   task automatic check_outputs_reset(input string tag);
      chk({tag, "_bit_tick"}, bit_tick, 1'b0);
      chk({tag, "_rx_en"}, rx_en, 1'b0);
      chk({tag, "_out_valid"}, out_valid, 1'b0);
      chk({tag, "_out_data"}, out_data, 32'd0);
      chk({tag, "_busy"}, busy, 1'b0);
      chk({tag, "_done"}, done, 1'b0);
      chk({tag, "_overflow"}, overflow, 1'b0);
      chk({tag, "_timeout"}, timeout, 1'b0);
   endtask

   // Scoreboard: every sent word delivered once, in order.
   task automatic check_delivery(input string tag, input int n);
      chk({tag, "_nsent"}, sent_q.size(), n);
      chk({tag, "_ngot"}, got_q.size(), n);
      for (int i = 0; i < n && i < got_q.size() && i < sent_q.size(); i++) begin
         chk({tag, "_word"}, got_q[i], sent_q[i]);
      end
   endtask

   initial begin
      int nt;
      int tprev;
      int cycles;
      int dn0;
      int rx0;
      int n;
      logic [31:0] exp_words[3];

      // ---- reset ----
      reset = 1'b0;
      cyc(3);
      check_outputs_reset("rst");
      reset = 1'b1;

      // ---- bit tick timing ----
      nt = 0;
      tprev = 0;
      for (int k = 1; k <= 160; k++) begin
         cyc(1);
         if (bit_tick) begin
            if (nt == 0) chk("tick_first", k, 49);
            else chk("tick_period", k - tprev, DIV);
            tprev = k;
            nt++;
         end
      end
      chk("tick_count", nt, 3);

      // ---- fixed three-word frame ----
      exp_words[0] = 32'hDEADBEEF;
      exp_words[1] = 32'h12345678;
      exp_words[2] = 32'hCAFEF00D;
      for (int i = 0; i < 3; i++) fixed_q.push_back(exp_words[i]);
      sent_q.delete();
      got_q.delete();
      out_ready = 1'b1;
      rcv_on = 1'b1;
      dn0 = done_cnt;
      start_frame(4'd3);
      wait_done("f3", 1000, cycles);
      cyc(6);
      chk("f3_ngot", got_q.size(), 3);
      for (int i = 0; i < 3 && i < got_q.size(); i++) chk("f3_word", got_q[i], exp_words[i]);
      chk("f3_done_cnt", done_cnt - dn0, 1);
      chk("f3_overflow", overflow, 1'b0);
      chk("f3_timeout", timeout, 1'b0);
      chk("f3_empty", out_valid, 1'b0);

      // ---- randomized frames, consumer always ready ----
      for (int f = 0; f < 5; f++) begin
         n = $urandom_range(1, 8);
         sent_q.delete();
         got_q.delete();
         dn0 = done_cnt;
         start_frame(4'(n));
         wait_done("rnd", 200 * n + 200, cycles);
         cyc(6);
         check_delivery("rnd", n);
         chk("rnd_done_cnt", done_cnt - dn0, 1);
         chk("rnd_overflow", overflow, 1'b0);
         chk("rnd_timeout", timeout, 1'b0);
         chk("rnd_busy", busy, 1'b0);
      end

      // ---- overflow: six words into a stalled four-word FIFO ----
      sent_q.delete();
      got_q.delete();
      out_ready = 1'b0;
      start_frame(4'd6);
      wait_done("ovf", 2000, cycles);
      cyc(1);
      chk("ovf_overflow", overflow, 1'b1);
      chk("ovf_timeout", timeout, 1'b0);
      chk("ovf_valid", out_valid, 1'b1);
      chk("ovf_nsent", sent_q.size(), 6);
      chk("ovf_ngot_stalled", got_q.size(), 0);
      out_ready = 1'b1;
      cyc(8);
      chk("ovf_ngot", got_q.size(), DEPTH);
      for (int i = 0; i < DEPTH && i < got_q.size() && i < sent_q.size(); i++)
         chk("ovf_word", got_q[i], sent_q[i]);
      chk("ovf_drained", out_valid, 1'b0);

      // ---- timeout: no receiver activity ----
      rcv_on = 1'b0;
      sent_q.delete();
      got_q.delete();
      dn0 = done_cnt;
      start_frame(4'd2);
      chk("to_flag_cleared", overflow, 1'b0);
      wait_done("to", 3000, cycles);
      chk("to_window", (cycles > (TO_TICKS - 1) * DIV) && (cycles <= TO_TICKS * DIV), 1'b1);
      chk("to_timeout", timeout, 1'b1);
      cyc(2);
      chk("to_done_cnt", done_cnt - dn0, 1);
      chk("to_empty", out_valid, 1'b0);
      chk("to_busy", busy, 1'b0);

      // ---- abort one cycle after start; starts during busy ignored ----
      dn0 = done_cnt;
      cyc(1);
      start = 1'b1;
      num_words = 4'd5;
      cyc(1);
      chk("ab_rx_en_on", rx_en, 1'b1);
      chk("ab_timeout_cleared", timeout, 1'b0);
      abort = 1'b1;
      cyc(1);
      abort = 1'b0;
      chk("ab_rx_en_off", rx_en, 1'b0);
      chk("ab_done", done, 1'b1);
      cyc(1);
      start = 1'b0;
      chk("ab_idle", busy, 1'b0);
      cyc(4);
      chk("ab_still_idle", busy, 1'b0);
      chk("ab_done_cnt", done_cnt - dn0, 1);
      chk("ab_rx_en_idle", rx_en, 1'b0);

      // ---- zero-word frame ----
      dn0 = done_cnt;
      rx0 = rxen_cnt;
      start_frame(4'd0);
      chk("z_done", done, 1'b1);
      cyc(3);
      chk("z_done_cnt", done_cnt - dn0, 1);
      chk("z_rx_en_never", rxen_cnt - rx0, 0);
      chk("z_busy", busy, 1'b0);

      // ---- reset mid-frame ----
      sent_q.delete();
      got_q.delete();
      out_ready = 1'b0;
      rcv_on = 1'b1;
      start_frame(4'd3);
      cycles = 0;
      while (!out_valid && cycles < 500) begin
         cyc(1);
         cycles++;
      end
      chk("mr_word_held", out_valid, 1'b1);
      rcv_on = 1'b0;
      reset = 1'b0;
      cyc(1);
      check_outputs_reset("mr");
      reset = 1'b1;
      cyc(5);
      chk("mr_after_valid", out_valid, 1'b0);
      chk("mr_after_busy", busy, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
